// File: rtl/alsu_res_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alsu_res_pkg
// Purpose : Shared types and constants for the ALSU result buffer slice.
//           - alarm_state_e : consecutive-invalid alarm FSM states
//           - alsu_res_t    : one captured ALSU result {invalid, out}
//           - RES_W         : width of a stored result without parity
// Options : ALSU_RES_PARITY_EN (see alsu_result_buffer) widens the stored
//           entry by one parity bit; the package itself is unaffected.
// Revision: 1.0 - initial release
// ============================================================================
package alsu_res_pkg;

    localparam int RES_W = 7;

    typedef enum logic [1:0] {
        OK    = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } alarm_state_e;

    typedef struct packed {
        logic              invalid;
        logic signed [5:0] out;
    } alsu_res_t;

endpackage
`default_nettype wire

// File: rtl/alsu_res_fifo.sv
`default_nettype none
// ============================================================================
// Module  : alsu_res_fifo
// Purpose : Synchronous register-based FIFO, first-word-fall-through.
//           The head entry is presented on rdata while the FIFO is non-empty
//           and forced to zero while empty, so stale contents never leak out
//           after a reset.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           push, wdata     - write request and data (dropped when full
//                             unless a pop happens in the same cycle)
//           pop             - read request (ignored when empty)
//           rdata           - head entry
//           full, empty     - decoded from the occupancy counter
// Revision: 1.0 - initial release
// ============================================================================
module alsu_res_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int                c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0]  c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic w_pop;
    logic w_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_FULL_CNT);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push when it is being read.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assign rdata = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/alsu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module  : alsu_result_buffer
// Purpose : Captures qualified ALSU results into a FIFO, presents them to a
//           consumer over valid/ready, keeps a saturating count of invalid
//           results and raises an alarm after ALARM_THRESH consecutive
//           captured invalid results.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           in_valid        - result qualifier (one capture per high cycle)
//           in_out          - signed 6-bit ALSU result, stored bit-exact
//           in_invalid      - ALSU invalid flag for this result
//           rd_ready        - consumer takes the head entry
//           rd_valid        - FIFO non-empty
//           rd_data         - head entry {invalid, out} (+ parity MSB)
//           full            - FIFO holds DEPTH entries
//           overflow        - sticky: a capture was dropped
//           invalid_cnt     - saturating count of invalid results
//           alarm           - consecutive-invalid alarm
//           alarm_clr       - clears alarm and overflow
// Options : ALSU_RES_PARITY_EN - when defined, each entry carries an even
//           parity bit over its 7 data bits, computed at push time, and
//           rd_data becomes 8 bits {parity, invalid, out}.
// Revision: 1.0 - initial release
// ============================================================================
module alsu_result_buffer
    import alsu_res_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int ALARM_THRESH = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [5:0]       in_out,
    input  logic             in_invalid,
    input  logic             rd_ready,
    output logic             rd_valid,
`ifdef ALSU_RES_PARITY_EN
    output logic [RES_W:0]   rd_data,
`else
    output logic [RES_W-1:0] rd_data,
`endif
    output logic             full,
    output logic             overflow,
    output logic [CNT_W-1:0] invalid_cnt,
    output logic             alarm,
    input  logic             alarm_clr
);

`ifdef ALSU_RES_PARITY_EN
    localparam int c_DATA_W = RES_W + 1;
`else
    localparam int c_DATA_W = RES_W;
`endif
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [7:0]       c_THRESH  = 8'(ALARM_THRESH);

    alsu_res_t           w_res;
    logic [c_DATA_W-1:0] w_wdata;
    logic [c_DATA_W-1:0] w_rdata;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_inv_evt;
    logic                w_ok_evt;

    logic [CNT_W-1:0]    r_invalid_cnt;
    logic                r_overflow;
    alarm_state_e        r_state;
    alarm_state_e        w_state_nxt;
    logic [7:0]          r_run;
    logic [7:0]          w_run_nxt;
    logic                r_alarm;

    assign w_res = '{invalid: in_invalid, out: in_out};

`ifdef ALSU_RES_PARITY_EN
    assign w_wdata = {^w_res, w_res};
`else
    assign w_wdata = w_res;
`endif

    alsu_res_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata (w_wdata),
        .pop   (rd_ready),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    assign rd_valid = !w_empty;
    assign rd_data  = w_rdata;
    assign full     = w_full;
    assign w_pop    = rd_ready && !w_empty;

    // Events are in_valid cycles only; idle cycles leave the FSM untouched.
    assign w_inv_evt = in_valid && in_invalid;
    assign w_ok_evt  = in_valid && !in_invalid;

    // ------------------------------------------------------------------
    // Sticky overflow: a capture arriving while full with no pop is lost.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (alarm_clr) begin
            r_overflow <= 1'b0;
        end else if (in_valid && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Invalid counter counts every invalid event, dropped or not.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_invalid_cnt <= '0;
        end else if (w_inv_evt && (r_invalid_cnt != c_CNT_MAX)) begin
            r_invalid_cnt <= r_invalid_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Consecutive-invalid alarm FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OK;
            r_run   <= 8'd0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_alarm <= (w_state_nxt == ALARM);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        case (r_state)
            OK: begin
                if (w_inv_evt) begin
                    w_run_nxt   = 8'd1;
                    w_state_nxt = (c_THRESH == 8'd1) ? ALARM : RUN;
                end else if (w_ok_evt) begin
                    w_run_nxt = 8'd0;
                end
            end
            RUN: begin
                if (w_inv_evt) begin
                    w_run_nxt = r_run + 8'd1;
                    if ((r_run + 8'd1) == c_THRESH) begin
                        w_state_nxt = ALARM;
                    end
                end else if (w_ok_evt) begin
                    w_run_nxt   = 8'd0;
                    w_state_nxt = OK;
                end
            end
            ALARM: begin
                // Latched until software acknowledges with alarm_clr.
            end
            default: begin
                w_state_nxt = OK;
                w_run_nxt   = 8'd0;
            end
        endcase
        // Clear overrides any event seen in the same cycle.
        if (alarm_clr) begin
            w_state_nxt = OK;
            w_run_nxt   = 8'd0;
        end
    end

    assign overflow    = r_overflow;
    assign invalid_cnt = r_invalid_cnt;
    assign alarm       = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_alsu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alsu_result_buffer
// Purpose : Self-checking bench for alsu_result_buffer. A main instance uses
//           default parameters; a second instance with CNT_W=3 shares the
//           same stimulus to show counter saturation.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alsu_result_buffer;
    import alsu_res_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [5:0] in_out;
    logic       in_invalid;
    logic       rd_ready;
    logic       alarm_clr;

    logic       rd_valid;
`ifdef ALSU_RES_PARITY_EN
    logic [RES_W:0]   rd_data;
    logic [RES_W:0]   rd_data3;
`else
    logic [RES_W-1:0] rd_data;
    logic [RES_W-1:0] rd_data3;
`endif
    logic       full;
    logic       overflow;
    logic [7:0] invalid_cnt;
    logic       alarm;

    logic       rd_valid3;
    logic       full3;
    logic       overflow3;
    logic [2:0] invalid_cnt3;
    logic       alarm3;

    logic [7:0] rd_data8;
    assign rd_data8 = 8'(rd_data);

    int n_tests = 0;
    int n_fail  = 0;

    alsu_result_buffer #(
        .DEPTH        (8),
        .ALARM_THRESH (4),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_out      (in_out),
        .in_invalid  (in_invalid),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .full        (full),
        .overflow    (overflow),
        .invalid_cnt (invalid_cnt),
        .alarm       (alarm),
        .alarm_clr   (alarm_clr)
    );

    alsu_result_buffer #(
        .DEPTH        (8),
        .ALARM_THRESH (4),
        .CNT_W        (3)
    ) dut3 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_out      (in_out),
        .in_invalid  (in_invalid),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid3),
        .rd_data     (rd_data3),
        .full        (full3),
        .overflow    (overflow3),
        .invalid_cnt (invalid_cnt3),
        .alarm       (alarm3),
        .alarm_clr   (alarm_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [5:0] out;
        logic       inv;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [6:0] ed;
        logic       ef;
        logic       eo;
        logic [7:0] ec;
        logic       ea;
    } vec_t;

    vec_t vecs [18];

    // Expected rd_data as seen on the port (parity bit added when enabled).
    function automatic logic [7:0] exp_data(input logic [6:0] d);
`ifdef ALSU_RES_PARITY_EN
        return {^d, d};
`else
        return {1'b0, d};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [5:0] o, input logic inv,
                         input logic rdy, input logic clr);
        in_valid   = iv;
        in_out     = o;
        in_invalid = inv;
        rd_ready   = rdy;
        alarm_clr  = clr;
    endtask

    task automatic do_rst();
        drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rd_valid"},    32'(rd_valid),    32'd0);
        check({tag, " rd_data"},     32'(rd_data8),    32'd0);
        check({tag, " full"},        32'(full),        32'd0);
        check({tag, " overflow"},    32'(overflow),    32'd0);
        check({tag, " invalid_cnt"}, 32'(invalid_cnt), 32'd0);
        check({tag, " alarm"},       32'(alarm),       32'd0);
    endtask

    logic [5:0] drain [8];

    initial begin
        //          rst iv  out    inv rdy clr | ev  ed     ef  eo  ec     ea
        vecs[0]  = '{0, 1, 6'h3B, 0, 0, 0,  1, 7'h3B, 0, 0, 8'd0, 0};
        vecs[1]  = '{0, 1, 6'h07, 1, 0, 0,  1, 7'h3B, 0, 0, 8'd1, 0};
        vecs[2]  = '{0, 0, 6'h00, 0, 1, 0,  1, 7'h47, 0, 0, 8'd1, 0};
        vecs[3]  = '{0, 0, 6'h00, 0, 1, 0,  0, 7'h00, 0, 0, 8'd1, 0};
        vecs[4]  = '{1, 1, 6'h15, 1, 1, 0,  0, 7'h00, 0, 0, 8'd0, 0};
        vecs[5]  = '{0, 1, 6'h01, 1, 1, 0,  1, 7'h41, 0, 0, 8'd1, 0};
        vecs[6]  = '{0, 1, 6'h02, 1, 1, 0,  1, 7'h42, 0, 0, 8'd2, 0};
        vecs[7]  = '{0, 1, 6'h03, 1, 1, 0,  1, 7'h43, 0, 0, 8'd3, 0};
        vecs[8]  = '{0, 0, 6'h00, 1, 0, 0,  1, 7'h43, 0, 0, 8'd3, 0};
        vecs[9]  = '{0, 1, 6'h04, 0, 1, 0,  1, 7'h04, 0, 0, 8'd3, 0};
        vecs[10] = '{0, 1, 6'h3F, 1, 1, 0,  1, 7'h7F, 0, 0, 8'd4, 0};
        vecs[11] = '{0, 1, 6'h20, 1, 1, 0,  1, 7'h60, 0, 0, 8'd5, 0};
        vecs[12] = '{0, 1, 6'h11, 1, 1, 0,  1, 7'h51, 0, 0, 8'd6, 0};
        vecs[13] = '{0, 1, 6'h2A, 1, 1, 0,  1, 7'h6A, 0, 0, 8'd7, 1};
        vecs[14] = '{0, 0, 6'h00, 0, 1, 0,  0, 7'h00, 0, 0, 8'd7, 1};
        vecs[15] = '{0, 1, 6'h05, 0, 0, 0,  1, 7'h05, 0, 0, 8'd7, 1};
        vecs[16] = '{0, 1, 6'h06, 1, 0, 1,  1, 7'h05, 0, 0, 8'd8, 0};
        vecs[17] = '{0, 1, 6'h07, 1, 0, 0,  1, 7'h05, 0, 0, 8'd9, 0};

        drain[0] = 6'h0A; drain[1] = 6'h0B; drain[2] = 6'h0C; drain[3] = 6'h0D;
        drain[4] = 6'h0E; drain[5] = 6'h0F; drain[6] = 6'h10; drain[7] = 6'h2C;

        // Reset state
        rst = 1'b1;
        drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;

        // Table: basic flow, reset with push, alarm run / clear
        for (int i = 0; i < 18; i++) begin
            rst = vecs[i].rst;
            drive(vecs[i].iv, vecs[i].out, vecs[i].inv, vecs[i].rdy, vecs[i].clr);
            step();
            check($sformatf("v%0d rd_valid", i),    32'(rd_valid),    32'(vecs[i].ev));
            check($sformatf("v%0d rd_data", i),     32'(rd_data8),    32'(exp_data(vecs[i].ed)));
            check($sformatf("v%0d full", i),        32'(full),        32'(vecs[i].ef));
            check($sformatf("v%0d overflow", i),    32'(overflow),    32'(vecs[i].eo));
            check($sformatf("v%0d invalid_cnt", i), 32'(invalid_cnt), 32'(vecs[i].ec));
            check($sformatf("v%0d alarm", i),       32'(alarm),       32'(vecs[i].ea));
        end
        rst = 1'b0;

        // Full and overflow: 9 pushes with no reads
        do_rst();
        for (int n = 1; n <= 9; n++) begin
            drive(1'b1, 6'(n + 8), 1'b0, 1'b0, 1'b0);
            step();
            check($sformatf("fill%0d full", n),     32'(full),     32'(n >= 8));
            check($sformatf("fill%0d overflow", n), 32'(overflow), 32'(n == 9));
            check($sformatf("fill%0d head", n),     32'(rd_data8), 32'(exp_data(7'h09)));
        end
        // Push and pop together while full
        drive(1'b1, 6'h2C, 1'b0, 1'b1, 1'b0);
        step();
        check("fullpp full",     32'(full),     32'd1);
        check("fullpp overflow", 32'(overflow), 32'd1);
        check("fullpp head",     32'(rd_data8), 32'(exp_data(7'h0A)));
        // Drain: the dropped ninth value (6'h11) must never show up
        for (int j = 1; j <= 8; j++) begin
            drive(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
            step();
            check($sformatf("drain%0d full", j), 32'(full), 32'd0);
            if (j < 8) begin
                check($sformatf("drain%0d rd_valid", j), 32'(rd_valid), 32'd1);
                check($sformatf("drain%0d head", j), 32'(rd_data8),
                      32'(exp_data({1'b0, drain[j]})));
            end else begin
                check("drain empty", 32'(rd_valid), 32'd0);
            end
        end
        drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
        step();
        check("clr overflow", 32'(overflow), 32'd0);

        // Saturation of the 3-bit counter
        do_rst();
        for (int n = 1; n <= 10; n++) begin
            drive(1'b1, 6'(n), 1'b1, 1'b1, 1'b0);
            step();
            if (n == 7) begin
                check("sat3 at 7", 32'(invalid_cnt3), 32'd7);
            end
        end
        check("sat3 final", 32'(invalid_cnt3), 32'd7);
        check("cnt8 final", 32'(invalid_cnt),  32'd10);

        // Reset mid-operation: 5 queued entries and alarm raised
        do_rst();
        for (int n = 1; n <= 5; n++) begin
            drive(1'b1, 6'(n + 32), 1'b1, 1'b0, 1'b0);
            step();
        end
        check("midrst alarm pre",    32'(alarm),    32'd1);
        check("midrst rd_valid pre", 32'(rd_valid), 32'd1);
        rst = 1'b1;
        drive(1'b1, 6'h2B, 1'b1, 1'b1, 1'b0);
        step();
        rst = 1'b0;
        check_all_zero("midrst");
        drive(1'b1, 6'h12, 1'b0, 1'b0, 1'b0);
        step();
        check("postrst rd_valid", 32'(rd_valid), 32'd1);
        check("postrst head",     32'(rd_data8), 32'(exp_data(7'h12)));
        drive(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
        step();
        check("postrst only one", 32'(rd_valid), 32'd0);

`ifdef ALSU_RES_PARITY_EN
        do_rst();
        drive(1'b1, 6'h01, 1'b0, 1'b0, 1'b0);
        step();
        check("parity 01", 32'(rd_data8), 32'h81);
        drive(1'b1, 6'h03, 1'b0, 1'b1, 1'b0);
        step();
        check("parity 03", 32'(rd_data8), 32'h03);
`endif

        drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alsu_result_buffer.md
Name: alsu_result_buffer

Overview:
- Downstream stage of the ALSU. Captures each qualified ALSU result (signed 6-bit out plus invalid flag) into a small FIFO.
- Presents captured results to a consumer (host or UART packer) over a valid/ready handshake.
- Keeps a saturating count of invalid results.
- Runs a consecutive-invalid alarm FSM, so a stuck-invalid ALSU is flagged without software polling leds.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- ALARM_THRESH, 4, consecutive captured invalid results that raise alarm; ≥1, ≤255.
- CNT_W, 8, width of the invalid-result counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ALSU result qualifier; capture when high.
- in_out  in  6  ALSU out, signed.
- in_invalid  in  1  ALSU invalid flag for this result.
- rd_ready  in  1  consumer accepts head entry.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  7  head entry {invalid, out[5:0]}; 8 bits with parity option.
- full  out  1  FIFO holds DEPTH entries.
- overflow  out  1  sticky; a capture was dropped.
- invalid_cnt  out  CNT_W  saturating count of captured invalid results.
- alarm  out  1  consecutive-invalid alarm.
- alarm_clr  in  1  clears alarm and overflow.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: rd_valid=0, rd_data=0, full=0, overflow=0, invalid_cnt=0, alarm=0. FSM goes to OK; wr_ptr=rd_ptr=0; occupancy=0. Reset wins over every other input in the same cycle, including mid-transfer; FIFO contents are discarded.
- Push: in_valid=1 and (not full, or pop in the same cycle) → entry {in_invalid, in_out} written at wr_ptr, wr_ptr increments modulo DEPTH.
- Pop: rd_valid && rd_ready → rd_ptr increments.
- rd_data is the registered head entry (FIFO read latency 0 from the consumer's view).
- A push into an empty FIFO makes rd_valid=1 on the next cycle.
- Full with push and pop together: both happen, occupancy unchanged, no overflow.
- Empty with push and pop together: pop ignored (rd_valid=0), push accepted.
- Full with push and no pop: entry dropped, overflow set on the next edge. overflow stays set until alarm_clr or rst.
- Pointers are log2(DEPTH) bits and wrap naturally. full and empty are decoded from a log2(DEPTH)+1-bit occupancy counter.
- invalid_cnt increments by 1 on every in_valid with in_invalid=1, even if the entry is dropped. It saturates at 2^CNT_W-1 and is cleared only by rst.
- Alarm FSM, with an 8-bit run counter; events are in_valid cycles only, and in_valid=0 cycles are ignored:
  - OK: invalid event → run=1; go to RUN, or go straight to ALARM if ALARM_THRESH=1.
  - RUN: invalid event → run+1; at run==ALARM_THRESH go to ALARM. A valid (non-invalid) event → run=0, go to OK.
  - ALARM: alarm=1 (registered, asserted the cycle after the threshold event). The state is held regardless of further events. alarm_clr → OK, run=0.
- alarm_clr in any state clears overflow. alarm_clr and an invalid event in the same cycle: clear wins for the FSM (→ OK, run=0), and the event is still counted in invalid_cnt.
- No arithmetic on in_out; it is stored bit-exact, with the sign preserved.

Optional Feature:
- Macro ALSU_RES_PARITY_EN.
- Defined: rd_data is 8 bits {parity, invalid, out[5:0]}, with parity = even parity (XOR) of the 7 stored bits, computed at push time and stored.
- Undefined: rd_data is 7 bits and no parity storage exists.

Decomposition:
- Package alsu_res_pkg holds:
  - typedef alarm_state_e {OK, RUN, ALARM};
  - typedef alsu_res_t packed struct {logic invalid; logic signed [5:0] out;};
  - localparam RES_W=7.
- One sub-module, alsu_res_fifo: parameterised DEPTH/width synchronous FIFO with push/pop/full/empty/occupancy. The top keeps the counter, FSM, overflow and parity.

Test Plan:
- Basic flow: rst, then push out=-5 (6'h3B) valid, then out=+7 invalid with rd_ready=0 → rd_valid=1 one cycle after the first push, rd_data=7'h3B; raise rd_ready → next rd_data=7'h47, then rd_valid=0.
- Full and overflow: DEPTH=8, push 9 entries with rd_ready=0 → full=1 after the 8th, overflow=1 after the 9th, and the 9th value never appears on rd_data. Push+pop while full → occupancy stays 8, overflow unchanged.
- Alarm: 3 invalid events, 1 valid event, then 4 invalid events → alarm stays 0 through the first run and rises the cycle after the 4th invalid of the second run. invalid_cnt=7. alarm_clr → alarm=0, overflow=0 next cycle.
- Saturation: CNT_W=3, 10 invalid events → invalid_cnt stops at 7.
- Reset mid-operation: 5 entries queued and alarm=1, assert rst for one cycle → all outputs 0 next cycle; the next push re-appears as the only entry.
- With ALSU_RES_PARITY_EN: push out=6'h01, invalid=0 → rd_data=8'h81. Push out=6'h03, invalid=0 → rd_data=8'h03.
